// File: rtl/load_store_unit_if.sv
// Bundles the MEM-stage request/response handshake and the data-RAM port of the load/store unit.
// The LSU connects through the slave modport; the pipeline/RAM side uses master.
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_stall;
    logic              mem_err;
    logic              lsu2ram_we;
    logic [ADDR_W-1:0] lsu2ram_addr;
    logic [DATA_W-1:0] lsu2ram_data;
    logic [DATA_W-1:0] ram2lsu_data;

    modport slave (
        input  mem_req, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata, ram2lsu_data,
        output mem_rdata, mem_done, mem_stall, mem_err, lsu2ram_we, lsu2ram_addr, lsu2ram_data
    );

    modport master (
        output mem_req, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata, ram2lsu_data,
        input  mem_rdata, mem_done, mem_stall, mem_err, lsu2ram_we, lsu2ram_addr, lsu2ram_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into
// word RAM cycles, with read-modify-write for sub-word stores and extended loads.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic              err_q;
    logic [15:0]       wdata_q;
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_data;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic              illegal;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    always_comb begin
        illegal = 1'b0;
        case (bus.mem_size)
            2'b01:   illegal = bus.mem_addr[0];
            2'b10:   illegal = (bus.mem_addr[1:0] != 2'b00);
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    if (illegal)
                        next_state = DONE;
                    else if (bus.mem_we && bus.mem_size == 2'b10)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ:    next_state = we_q ? WRITE : DONE;
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Merge is taken from the live RAM read so the write data is ready in the WRITE cycle.
    always_comb begin
        merged = bus.ram2lsu_data;
        case (size_q)
            2'b00:   merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
            default: merged = bus.ram2lsu_data;
        endcase
    end

    always_comb begin
        lane_b = rd_buf[{off_q, 3'b000} +: 8];
        lane_h = rd_buf[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_data = uns_q ? {{(DATA_W-8){1'b0}}, lane_b}
                                       : {{(DATA_W-8){lane_b[7]}}, lane_b};
            2'b01:   load_data = uns_q ? {{(DATA_W-16){1'b0}}, lane_h}
                                       : {{(DATA_W-16){lane_h[15]}}, lane_h};
            default: load_data = rd_buf;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            off_q    <= '0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rd_buf   <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            state  <= next_state;
            ram_we <= (next_state == WRITE);
            if (state == IDLE && bus.mem_req) begin
                we_q     <= bus.mem_we;
                size_q   <= bus.mem_size;
                uns_q    <= bus.mem_unsigned;
                off_q    <= bus.mem_addr[1:0];
                err_q    <= illegal;
                wdata_q  <= bus.mem_wdata[15:0];
                ram_addr <= {2'b00, bus.mem_addr[ADDR_W-1:2]};
                if (bus.mem_we && bus.mem_size == 2'b10)
                    ram_data <= bus.mem_wdata;
            end
            if (state == READ) begin
                rd_buf <= bus.ram2lsu_data;
                if (we_q)
                    ram_data <= merged;
            end
        end
    end

    assign bus.lsu2ram_we   = ram_we;
    assign bus.lsu2ram_addr = ram_addr;
    assign bus.lsu2ram_data = ram_data;
    assign bus.mem_done     = (state == DONE);
    assign bus.mem_err      = (state == DONE) && err_q;
    assign bus.mem_rdata    = (state == DONE && !we_q && !err_q) ? load_data : '0;
    assign bus.mem_stall    = bus.mem_req && !bus.mem_done;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives requests, models a 16-word RAM,
// and compares against hand-computed results.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_clr = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] ram [16];

    load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.ram2lsu_data = ram[bus.lsu2ram_addr[3:0]];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (bus.lsu2ram_we) begin
            ram[bus.lsu2ram_addr[3:0]] <= bus.lsu2ram_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts just after a rising edge; cycle 1 is the IDLE cycle that accepts the request.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                          output int done_cyc, output logic [31:0] rdata, output logic err,
                          output int we_cnt, output int we_cyc, output int stall_cnt);
        bus.mem_we = we;
        bus.mem_size = size;
        bus.mem_unsigned = uns;
        bus.mem_addr = addr;
        bus.mem_wdata = wdata;
        bus.mem_req = 1'b1;
        done_cyc = 0;
        rdata = 'x;
        err = 1'bx;
        we_cnt = 0;
        we_cyc = 0;
        stall_cnt = 0;
        for (int c = 1; c <= 10 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.lsu2ram_we) begin
                we_cnt++;
                we_cyc = c;
            end
            if (bus.mem_stall) stall_cnt++;
            if (bus.mem_done) begin
                done_cyc = c;
                rdata = bus.mem_rdata;
                err = bus.mem_err;
            end
            @(posedge clk);
            #1;
            if (c == 1 && done_cyc == 0) begin
                bus.mem_we = ~we;
                bus.mem_size = size ^ 2'b01;
                bus.mem_unsigned = ~uns;
                bus.mem_addr = ~addr;
                bus.mem_wdata = ~wdata;
            end
        end
        if (!hold || done_cyc == 0) begin
            bus.mem_req = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    int          dc, wc, wcy, sc;
    logic [31:0] rd;
    logic        er;
    bit          saw_done;

    typedef struct {
        string       tag;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads [6] = '{
        '{"lb_13",  2'b00, 1'b0, 32'h13, 32'hFFFF_FFDE},
        '{"lbu_13", 2'b00, 1'b1, 32'h13, 32'h0000_00DE},
        '{"lh_10",  2'b01, 1'b0, 32'h10, 32'hFFFF_BEEF},
        '{"lhu_12", 2'b01, 1'b1, 32'h12, 32'h0000_DE55},
        '{"lb_12",  2'b00, 1'b0, 32'h12, 32'h0000_0055},
        '{"lw_10",  2'b10, 1'b0, 32'h10, 32'hDE55_BEEF}
    };

    initial begin
        bus.mem_req = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_size = 2'b00;
        bus.mem_unsigned = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        ram_clr = 1'b0;
        check("rst_done", {31'b0, bus.mem_done}, 32'h0);
        check("rst_err", {31'b0, bus.mem_err}, 32'h0);
        check("rst_we", {31'b0, bus.lsu2ram_we}, 32'h0);
        check("rst_addr", bus.lsu2ram_addr, 32'h0);
        check("rst_wdata", bus.lsu2ram_data, 32'h0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_stall", {31'b0, bus.mem_stall}, 32'h0);

        // SW 0x10
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, dc, rd, er, wc, wcy, sc);
        check("sw_done_cyc", dc, 3);
        check("sw_we_cyc", wcy, 2);
        check("sw_we_cnt", wc, 1);
        check("sw_stall_cnt", sc, 2);
        check("sw_rdata", rd, 32'h0);
        check("sw_ram4", ram[4], 32'hDEAD_BEEF);

        // SB 0x12 read-modify-write
        access(1'b1, 2'b00, 1'b0, 32'h12, 32'hAAAA_AA55, 1'b0, dc, rd, er, wc, wcy, sc);
        check("sb_done_cyc", dc, 4);
        check("sb_we_cyc", wcy, 3);
        check("sb_stall_cnt", sc, 3);
        check("sb_ram4", ram[4], 32'hDE55_BEEF);

        foreach (loads[i]) begin
            access(1'b0, loads[i].size, loads[i].uns, loads[i].addr, 32'h0, 1'b0,
                   dc, rd, er, wc, wcy, sc);
            check({loads[i].tag, "_data"}, rd, loads[i].exp);
            check({loads[i].tag, "_cyc"}, dc, 3);
            check({loads[i].tag, "_we"}, wc, 0);
        end

        // SH upper half of word 5
        access(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_A5A5, 1'b0, dc, rd, er, wc, wcy, sc);
        check("sh_done_cyc", dc, 4);
        check("sh_ram5", ram[5], 32'hA5A5_0000);
        access(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0, dc, rd, er, wc, wcy, sc);
        check("lh_16", rd, 32'hFFFF_A5A5);

        // Misaligned / illegal accesses
        access(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF_FFFF, 1'b0, dc, rd, er, wc, wcy, sc);
        check("sh11_err", {31'b0, er}, 32'h1);
        check("sh11_cyc", dc, 2);
        check("sh11_we", wc, 0);
        access(1'b0, 2'b10, 1'b0, 32'h16, 32'h0, 1'b0, dc, rd, er, wc, wcy, sc);
        check("lw16_err", {31'b0, er}, 32'h1);
        check("lw16_cyc", dc, 2);
        check("lw16_rdata", rd, 32'h0);
        access(1'b1, 2'b11, 1'b0, 32'h10, 32'h0BAD_0BAD, 1'b0, dc, rd, er, wc, wcy, sc);
        check("sz11_err", {31'b0, er}, 32'h1);
        check("sz11_cyc", dc, 2);
        check("sz11_we", wc, 0);
        check("err_ram4", ram[4], 32'hDE55_BEEF);
        check("err_ram5", ram[5], 32'hA5A5_0000);

        // Reset during the WRITE cycle of an SB
        bus.mem_we = 1'b1;
        bus.mem_size = 2'b00;
        bus.mem_unsigned = 1'b0;
        bus.mem_addr = 32'h10;
        bus.mem_wdata = 32'h77;
        bus.mem_req = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rstw_we_before", {31'b0, bus.lsu2ram_we}, 32'h1);
        rst = 1'b1;
        #1;
        check("rstw_we_after", {31'b0, bus.lsu2ram_we}, 32'h0);
        saw_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.mem_done) saw_done = 1'b1;
        end
        check("rstw_no_done", {31'b0, saw_done}, 32'h0);
        check("rstw_ram4", ram[4], 32'hDE55_BEEF);
        @(posedge clk);
        #1;
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0102_0304, 1'b0, dc, rd, er, wc, wcy, sc);
        check("post_rst_sw_cyc", dc, 3);
        check("post_rst_ram4", ram[4], 32'h0102_0304);

        // Back-to-back LW then SW with mem_req held high
        access(1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0, dc, rd, er, wc, wcy, sc);
        access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, dc, rd, er, wc, wcy, sc);
        check("b2b_lw_cyc", dc, 3);
        check("b2b_lw_data", rd, 32'h1234_5678);
        access(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D, 1'b0, dc, rd, er, wc, wcy, sc);
        check("b2b_sw_cyc", dc + 3, 6);
        check("b2b_ram1", ram[1], 32'hCAFE_F00D);
        check("b2b_ram0", ram[0], 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
